// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, RTS, 10-bit frame, ACK check).
// Define PS2_TX_GLITCH_FILTER_EN to filter the device clock before edge detection.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iSend,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DATA,
    output logic       oPS2_CLK_LOW,
    output logic       oPS2_DATA_LOW,
    output logic       oReady,
    output logic       oDone,
    output logic       oError
);

    localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                          INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        DATA,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bits_q, bits_d;
    logic          data_low_q, data_low_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [1:0]    clk_sync_q, data_sync_q;
    logic          clk_prev_q;
    logic          clk_s, data_s, fall, expired;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], iPS2_CLK};
            data_sync_q <= {data_sync_q[0], iPS2_DATA};
            clk_prev_q  <= clk_s;
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    // Window = FILTER_LEN newest synced samples; output moves only on a unanimous window.
    logic [FILTER_LEN-2:0] filt_hist_q;
    logic [FILTER_LEN-1:0] filt_win;
    logic                  filt_q;

    assign filt_win = {filt_hist_q, clk_sync_q[1]};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            filt_hist_q <= '1;
            filt_q      <= 1'b1;
        end else begin
            filt_hist_q <= filt_win[FILTER_LEN-2:0];
            if (&filt_win)
                filt_q <= 1'b1;
            else if (~|filt_win)
                filt_q <= 1'b0;
        end
    end

    assign clk_s = filt_q;
`else
    assign clk_s = clk_sync_q[1];
`endif

    assign data_s  = data_sync_q[1];
    assign fall    = clk_prev_q & ~clk_s;
    assign expired = (cnt_q == '0);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '1;
            bits_q     <= '0;
            data_low_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            bits_q     <= bits_d;
            data_low_q <= data_low_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        bits_d     = bits_q;
        data_low_d = data_low_q;
        done_d     = 1'b0;
        error_d    = 1'b0;

        // Shared watchdog: reload on every device falling edge.
        if (state_q inside {RTS, DATA, ACK, WAIT_IDLE}) begin
            if (fall)
                cnt_d = TO_LOAD;
            else if (!expired)
                cnt_d = cnt_q - CW'(1);
        end

        unique case (state_q)
            IDLE: begin
                data_low_d = 1'b0;
                if (iSend) begin
                    shift_d = {1'b1, ~^iData, iData};
                    bits_d  = '0;
                    cnt_d   = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d      = TO_LOAD;
                    data_low_d = 1'b1;
                    state_d    = RTS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RTS, DATA: begin
                if (fall) begin
                    data_low_d = ~shift_q[0];
                    shift_d    = {1'b1, shift_q[9:1]};
                    bits_d     = (bits_q == 4'd10) ? bits_q : bits_q + 4'd1;
                    state_d    = (bits_q == 4'd9) ? ACK : DATA;
                end else if (expired) begin
                    data_low_d = 1'b0;
                    error_d    = 1'b1;
                    state_d    = IDLE;
                end
            end
            ACK: begin
                if (fall) begin
                    if (!data_s) begin
                        state_d = WAIT_IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end else if (expired) begin
                    data_low_d = 1'b0;
                    error_d    = 1'b1;
                    state_d    = IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (!fall && expired) begin
                    data_low_d = 1'b0;
                    error_d    = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                data_low_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    assign oPS2_CLK_LOW  = (state_q == INHIBIT);
    assign oPS2_DATA_LOW = data_low_q |
                           ((state_q == INHIBIT) && (cnt_q == INH_LAST));
    assign oReady        = (state_q == IDLE);
    assign oDone         = done_q;
    assign oError        = error_q;

endmodule
